mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage that sits directly downstream of the main decoder. It consumes the decoder's MemRead, MemWrite, MemDataSize and MemDataSign strobes together with the ALU address and the rt store value. It drives a word-wide handshaked memory port, performs sub-word extraction with sign or zero extension and read-modify-write for SB/SH, and stalls the core until each access completes. It also latches a sticky error record for misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT, 255: maximum number of cycles that mem_req may wait for mem_ack before the access is aborted; legal range 1..1023.
- clk  in  1  Single clock; all state changes on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- MemRead  in  1  Load request from the decoder.
- MemWrite  in  1  Store request from the decoder.
- MemDataSize  in  2  Access size: 11 word, 10 half, 01 byte, 00 illegal.
- MemDataSign  in  1  Load extension: 1 sign-extend, 0 zero-extend. Ignored for stores.
- addr  in  32  Byte address from the ALU.
- wdata  in  32  Store data (rt); the low byte or half is used for SB/SH.
- err_clr  in  1  Synchronous clear of the sticky error record.
- rdata  out  32  Extended load result; registered.
- stall  out  1  Holds PC and the pipeline while an access is in progress.
- mem_req  out  1  Memory request.
- mem_we  out  1  Memory write enable; valid while mem_req is high.
- mem_addr  out  32  Word address {addr[31:2],2'b00}.
- mem_wdata  out  32  Full word to write.
- mem_rdata  in  32  Word returned by memory; valid when mem_ack is high.
- mem_ack  in  1  Single-cycle completion from memory.
- error  out  1  Sticky error flag.
- err_code  out  2  01 misaligned, 10 timeout, 11 illegal.
- err_addr  out  32  Byte address of the first recorded error.

## Operation
- Byte lanes are little-endian: lane n occupies bits 8n+7:8n and is selected by addr[1:0]. A half-word occupies bits 15:0 when addr[1]=0 and bits 31:16 when addr[1]=1.
- The state machine has four states: IDLE, RD, WR, DONE.
- In IDLE, a request is MemRead or MemWrite being high.
- A request is illegal if MemRead and MemWrite are both high, or if MemDataSize=00. An illegal request raises error with code 11. It performs no memory access and does not stall.
- A request is misaligned if it is a word access with addr[1:0]!=0, or a half access with addr[0]!=0. It raises error with code 01. It performs no memory access and does not stall.
- For a legal request, the block latches addr, wdata, size, sign and op when it leaves IDLE. All request inputs are ignored until the block returns to IDLE.
  - A load goes IDLE→RD→DONE.
  - A word store goes IDLE→WR→DONE.
  - A byte or half store goes IDLE→RD→WR→DONE (read-modify-write).
- In RD: mem_req=1, mem_we=0. On mem_ack:
  - For a load, rdata is loaded with the selected lane, sign- or zero-extended to 32 bits.
  - For a sub-word store, the read word is merged: the target lane is replaced by wdata[7:0] or wdata[15:0] and the other lanes are kept. The merged word is placed in mem_wdata.
- In WR: mem_req=1, mem_we=1. mem_wdata holds either the merged word or the full wdata.
- mem_addr and mem_wdata stay constant while mem_req is high. mem_ack is ignored outside RD and WR.
- Watchdog: a counter is cleared on entry to RD or WR and increments on every cycle without an ack. When the counter reaches TIMEOUT:
  - mem_req drops;
  - error is recorded with code 10;
  - the state moves to DONE;
  - rdata is left unchanged.
- DONE lasts one cycle with stall=0, so the core advances; the next state is always IDLE.
- Error record: only the first error is captured (code and addr) and error stays set. err_clr clears all three fields. If err_clr and a new error occur in the same cycle, the new error is recorded.
- rdata holds its value until the next successful load.

## Timing
- Reset values: state IDLE; stall, mem_req, mem_we, error all 0; rdata, mem_addr, mem_wdata, err_addr all 0; err_code 00; watchdog counter 0.
- Asserting reset mid-access drops mem_req asynchronously. Any partial store is abandoned.
- stall is combinational. It is 1 in IDLE when a legal request is present, and 1 in RD and WR. It is 0 in DONE and 0 while reset is asserted.
- mem_ack is sampled on the rising edge while mem_req is high. An ack may arrive in the first request cycle.
- Minimum latency with ack on the first request cycle, counting cycle 0 as the IDLE cycle that accepts the request:
  - Load: stall is high in cycles 0–1 and rdata is valid in cycle 2 (DONE).
  - Word store: same timing as a load.
  - Sub-word store: stall is high in cycles 0–2 and DONE is cycle 3.
- Each cycle without an ack adds one cycle to the relevant phase.
- After DONE, a back-to-back request is accepted in the following IDLE cycle.

## Test plan
- LB at addr 0x1003; memory word 0x80FF7F01; ack after 2 cycles → rdata=0xFFFFFF80, stall is high for 3 cycles, mem_addr=0x1000. Repeat as LBU → rdata=0x00000080.
- LH at 0x2002; memory word 0x9ABC1234 → rdata=0xFFFF9ABC. LHU at 0x2000 → rdata=0x00001234.
- SB at 0x3001 with wdata=0x000000AA; memory word 0x11223344 → one read then one write with mem_wdata=0x1122AA44, mem_we=1 only in WR. SH at 0x3002 with wdata=0xBEEF → written word 0xBEEF3344.
- LW at 0x4002 → no mem_req, stall=0, error=1, err_code=01, err_addr=0x4002. A following illegal request (MemRead=MemWrite=1) must not overwrite the record. After err_clr, error=0.
- TIMEOUT=4 and mem_ack never asserted → mem_req is high for 4 cycles, then DONE, error=1, err_code=10, rdata unchanged.
- Assert reset during RD of an SB → mem_req falls immediately, state is IDLE, rdata=0, and no write is issued after reset is released.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: word port handshake, sub-word load extension,
// read-modify-write for SB/SH, watchdog and a sticky error record.
// Ports: clk, reset (async high); decoder strobes MemRead/MemWrite,
//   MemDataSize, MemDataSign; addr, wdata; err_clr.
//   Outputs rdata, stall; memory port mem_req/mem_we/mem_addr/mem_wdata,
//   mem_rdata/mem_ack; error record error/err_code/err_addr.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemDataSize,
  input  logic        MemDataSign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        err_clr,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [9:0] LP_TMAX = 10'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_store;
  logic [9:0]  r_cnt;

  logic        w_req;
  logic        w_illegal;
  logic        w_misal;
  logic        w_legal;
  logic        w_busy;
  logic        w_tmo;
  logic        w_err_set;
  logic [1:0]  w_err_code;
  logic [31:0] w_err_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_req     = MemRead | MemWrite;
  assign w_illegal = w_req & ((MemRead & MemWrite) | (MemDataSize == 2'b00));
  assign w_misal   = w_req & ~w_illegal &
                     (((MemDataSize == 2'b11) & (addr[1:0] != 2'b00)) |
                      ((MemDataSize == 2'b10) & addr[0]));
  assign w_legal   = w_req & ~w_illegal & ~w_misal;

  assign w_busy = (r_state == RD) | (r_state == WR);
  assign stall  = ~reset & (((r_state == IDLE) & w_legal) | w_busy);

  // Abort on the cycle the counter would reach TIMEOUT; a late ack wins.
  assign w_tmo = w_busy & ~mem_ack & (r_cnt == LP_TMAX);

  assign w_err_set  = ((r_state == IDLE) & (w_illegal | w_misal)) | w_tmo;
  assign w_err_code = w_tmo ? 2'b10 : (w_illegal ? 2'b11 : 2'b01);
  assign w_err_addr = w_tmo ? r_addr : addr;

  always_comb begin
    w_byte  = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half  = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext   = mem_rdata;
    w_merge = mem_rdata;
    unique case (1'b1)
      (r_size == 2'b01): begin
        w_ext = {{24{r_sign & w_byte[7]}}, w_byte};
        w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end
      (r_size == 2'b10): begin
        w_ext = {{16{r_sign & w_half[15]}}, w_half};
        w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_sign    <= 1'b0;
      r_store   <= 1'b0;
      r_cnt     <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
      err_code  <= 2'b00;
      err_addr  <= '0;
    end else begin
      // First error wins; a new error in the clear cycle is kept.
      if (w_err_set && (!error || err_clr)) begin
        error    <= 1'b1;
        err_code <= w_err_code;
        err_addr <= w_err_addr;
      end else if (err_clr) begin
        error    <= 1'b0;
        err_code <= 2'b00;
        err_addr <= '0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_legal) begin
            r_addr   <= addr;
            r_wdata  <= wdata;
            r_size   <= MemDataSize;
            r_sign   <= MemDataSign;
            r_store  <= MemWrite;
            r_cnt    <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {addr[31:2], 2'b00};
            if (MemWrite && (MemDataSize == 2'b11)) begin
              r_state   <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              r_state <= RD;
              mem_we  <= 1'b0;
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            r_cnt <= '0;
            if (r_store) begin
              r_state   <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= w_merge;
            end else begin
              r_state <= DONE;
              rdata   <= w_ext;
              mem_req <= 1'b0;
            end
          end else if (w_tmo) begin
            r_state <= DONE;
            mem_req <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        WR: begin
          if (mem_ack || w_tmo) begin
            r_state <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with scoreboard queue, plus
// sequences for error record, watchdog and mid-access reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  MemDataSize = 2'b00;
  logic        MemDataSign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        err_clr = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemDataSize(MemDataSize), .MemDataSign(MemDataSign),
    .addr(addr), .wdata(wdata), .err_clr(err_clr),
    .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .error(error), .err_code(err_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder: one word, programmable ack delay.
  logic [31:0] mword = '0;
  logic [31:0] last_maddr = '0;
  logic [31:0] last_wword = '0;
  int          ack_dly = 0;
  bit          ack_en = 1'b1;
  int          wcnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      last_maddr = mem_addr;
      if (ack_en && wcnt == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mword;
        if (mem_we) begin
          n_wr++;
          last_wword = mem_wdata;
          mword = mem_wdata;
        end else begin
          n_rd++;
        end
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Presents one request in an IDLE cycle and runs until stall drops.
  task automatic run_req(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int nst, output int nreq);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemDataSize = sz;
    MemDataSign = sg; addr = a; wdata = wd;
    #1;
    nst = stall ? 1 : 0;
    nreq = 0;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int g = 0; g < 40 && stall; g++) begin
      nst++;
      if (mem_req) nreq++;
      @(posedge clk); #1;
    end
    if (stall) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_bound: stall stuck high");
    end
  endtask

  task automatic clr_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mw;
    int          dly;
    logic [31:0] xr;
    int          xst;
    int          xrd;
    int          xwr;
    logic [31:0] xww;
    logic [1:0]  xcode;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    int          st;
    int          rdn;
    int          wrn;
    logic [31:0] ww;
    logic [1:0]  code;
    logic [31:0] ea;
    logic [31:0] ma;
  } exp_t;

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz,
      logic sg, logic [31:0] a, logic [31:0] wd, logic [31:0] mw,
      int dly, logic [31:0] xr, int xst, int xrd, int xwr,
      logic [31:0] xww, logic [1:0] xcode);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.mw = mw; v.dly = dly; v.xr = xr; v.xst = xst; v.xrd = xrd;
    v.xwr = xwr; v.xww = xww; v.xcode = xcode;
    return v;
  endfunction

  vec_t        vt[$];
  exp_t        sb[$];
  logic [31:0] m_rdata = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int nst;
    int nreq;
    exp_t e;

    // Reset state, with a request present that must not stall.
    MemRead = 1'b1; MemDataSize = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    MemRead = 1'b0; MemDataSize = 2'b00;
    reset = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_err", {29'd0, error, err_code}, 32'd0);
    chk("rst_eaddr", err_addr, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);

    //        rd wr sz    sg addr         wdata        memword      d
    //        rdata        st rd wr wword        code
    vt.push_back(mk(1,0,2'b01,1,32'h1003,32'h0,32'h80FF7F01,1,
                    32'hFFFFFF80,3,1,0,32'h0,2'b00));
    vt.push_back(mk(1,0,2'b01,0,32'h1003,32'h0,32'h80FF7F01,0,
                    32'h00000080,2,1,0,32'h0,2'b00));
    vt.push_back(mk(1,0,2'b10,1,32'h2002,32'h0,32'h9ABC1234,0,
                    32'hFFFF9ABC,2,1,0,32'h0,2'b00));
    vt.push_back(mk(1,0,2'b10,0,32'h2000,32'h0,32'h9ABC1234,0,
                    32'h00001234,2,1,0,32'h0,2'b00));
    vt.push_back(mk(1,0,2'b11,1,32'h5000,32'h0,32'hDEADBEEF,2,
                    32'hDEADBEEF,4,1,0,32'h0,2'b00));
    vt.push_back(mk(1,0,2'b01,1,32'h1001,32'h0,32'h80FF7F01,0,
                    32'h0000007F,2,1,0,32'h0,2'b00));
    vt.push_back(mk(1,0,2'b10,0,32'h2002,32'h0,32'h9ABC1234,0,
                    32'h00009ABC,2,1,0,32'h0,2'b00));
    vt.push_back(mk(0,1,2'b01,0,32'h3001,32'hAA,32'h11223344,0,
                    32'h0,3,1,1,32'h1122AA44,2'b00));
    vt.push_back(mk(0,1,2'b10,0,32'h3002,32'hBEEF,32'h11223344,0,
                    32'h0,3,1,1,32'hBEEF3344,2'b00));
    vt.push_back(mk(0,1,2'b11,0,32'h3004,32'hCAFEF00D,32'h0,1,
                    32'h0,3,0,1,32'hCAFEF00D,2'b00));
    vt.push_back(mk(0,1,2'b01,0,32'h3003,32'h12345655,32'h11223344,1,
                    32'h0,5,1,1,32'h55223344,2'b00));
    vt.push_back(mk(0,1,2'b10,0,32'h3000,32'h1234BEEF,32'hAABBCCDD,0,
                    32'h0,3,1,1,32'hAABBBEEF,2'b00));
    vt.push_back(mk(1,0,2'b11,0,32'h4002,32'h0,32'h0,0,
                    32'h0,0,0,0,32'h0,2'b01));
    vt.push_back(mk(0,1,2'b10,0,32'h3001,32'h0,32'h0,0,
                    32'h0,0,0,0,32'h0,2'b01));
    vt.push_back(mk(1,0,2'b00,0,32'h0010,32'h0,32'h0,0,
                    32'h0,0,0,0,32'h0,2'b11));
    vt.push_back(mk(1,1,2'b11,0,32'h0020,32'h0,32'h0,0,
                    32'h0,0,0,0,32'h0,2'b11));
    vt.push_back(mk(1,0,2'b01,1,32'h0102,32'h0,32'h00800000,0,
                    32'hFFFFFF80,2,1,0,32'h0,2'b00));

    foreach (vt[i]) begin
      clr_err();
      mword = vt[i].mw; ack_dly = vt[i].dly; ack_en = 1'b1;
      n_rd = 0; n_wr = 0; last_wword = '0;
      if (vt[i].rd && !vt[i].wr && vt[i].xcode == 2'b00)
        m_rdata = vt[i].xr;
      e.r = m_rdata; e.st = vt[i].xst; e.rdn = vt[i].xrd;
      e.wrn = vt[i].xwr; e.ww = vt[i].xww; e.code = vt[i].xcode;
      e.ea = (vt[i].xcode != 2'b00) ? vt[i].a : 32'h0;
      e.ma = {vt[i].a[31:2], 2'b00};
      sb.push_back(e);
      run_req(vt[i].rd, vt[i].wr, vt[i].sz, vt[i].sg, vt[i].a,
              vt[i].wd, nst, nreq);
      e = sb.pop_front();
      chk($sformatf("v%0d_rdata", i), rdata, e.r);
      chk($sformatf("v%0d_stall", i), nst, e.st);
      chk($sformatf("v%0d_nrd", i), n_rd, e.rdn);
      chk($sformatf("v%0d_nwr", i), n_wr, e.wrn);
      if (e.wrn != 0)
        chk($sformatf("v%0d_wword", i), last_wword, e.ww);
      if (e.rdn + e.wrn != 0) begin
        chk($sformatf("v%0d_maddr", i), last_maddr, e.ma);
        chk($sformatf("v%0d_done_req", i), {31'd0, mem_req}, 32'd0);
      end
      chk($sformatf("v%0d_err", i), {31'd0, error},
          {31'd0, e.code != 2'b00});
      chk($sformatf("v%0d_code", i), {30'd0, err_code}, {30'd0, e.code});
      chk($sformatf("v%0d_eaddr", i), err_addr, e.ea);
      @(posedge clk);
    end

    // Sticky first error, then clear racing a new error, then clear.
    clr_err();
    run_req(1, 0, 2'b11, 0, 32'h4002, 32'h0, nst, nreq);
    chk("seq_mis_stall", nst, 0);
    chk("seq_mis_rec", {error, err_code, err_addr[28:0]},
        {1'b1, 2'b01, 29'h4002});
    run_req(1, 1, 2'b11, 0, 32'h7777, 32'h0, nst, nreq);
    chk("seq_keep_code", {30'd0, err_code}, 32'd1);
    chk("seq_keep_addr", err_addr, 32'h4002);
    @(negedge clk);
    err_clr = 1'b1; MemRead = 1'b1; MemDataSize = 2'b00; addr = 32'h5555;
    @(negedge clk);
    err_clr = 1'b0; MemRead = 1'b0;
    chk("seq_race_rec", {error, err_code, err_addr[28:0]},
        {1'b1, 2'b11, 29'h5555});
    clr_err();
    chk("seq_clr", {error, err_code, err_addr[28:0]}, 32'd0);

    // Watchdog: no ack ever.
    ack_en = 1'b0; n_rd = 0; n_wr = 0;
    run_req(1, 0, 2'b11, 0, 32'h6000, 32'h0, nst, nreq);
    chk("tmo_reqcyc", nreq, 4);
    chk("tmo_stall", nst, 5);
    chk("tmo_rec", {error, err_code, err_addr[28:0]},
        {1'b1, 2'b10, 29'h6000});
    chk("tmo_rdata", rdata, m_rdata);
    @(posedge clk);
    clr_err();

    // Reset during RD of an SB.
    ack_en = 1'b0;
    @(negedge clk);
    MemWrite = 1'b1; MemDataSize = 2'b01; addr = 32'h3001; wdata = 32'hAA;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    chk("rmw_in_rd", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmw_rst_req", {31'd0, mem_req}, 32'd0);
    chk("rmw_rst_stall", {31'd0, stall}, 32'd0);
    chk("rmw_rst_rdata", rdata, 32'h0);
    m_rdata = '0;
    n_rd = 0; n_wr = 0; ack_en = 1'b1; ack_dly = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rmw_no_wr", n_wr + n_rd, 0);
    chk("rmw_idle_req", {31'd0, mem_req}, 32'd0);

    // Recovery after reset.
    mword = 32'h12345678;
    run_req(1, 0, 2'b11, 0, 32'h5000, 32'h0, nst, nreq);
    chk("rec_rdata", rdata, 32'h12345678);
    chk("rec_stall", nst, 2);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
